pq_dispatch: RTL

PQ_DISPATCH -- requirements
Module: pq_dispatch

---
 rtl/pq_dispatch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pq_dispatch.sv
// Min-event dispatcher: arbitrates enqueue/dequeue strobes to an external priority queue.
// Optional direct input-to-output path when the queue is empty: define PQ_BYPASS_EN.
module pq_dispatch #(
  parameter int unsigned DW      = 16,
  parameter int unsigned CAP     = 31,
  parameter int unsigned DEQ_GAP = 1
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          ev_in_valid,
  output logic          ev_in_ready,
  input  logic [DW-1:0] ev_in_data,
  output logic          ev_out_valid,
  input  logic          ev_out_ready,
  output logic [DW-1:0] ev_out_data,
  output logic          q_enq,
  output logic          q_deq,
  output logic [DW-1:0] q_inp_data,
  input  logic [DW-1:0] q_out_data,
  input  logic [4:0]    q_count,
  output logic          q_rst_n
);

  localparam int unsigned CW     = 5;
  localparam int unsigned GW     = (DEQ_GAP > 1) ? $clog2(DEQ_GAP + 1) : 1;
  localparam logic [CW-1:0] CAP_C  = CW'(CAP);
  localparam logic [GW-1:0] GAP_C  = GW'(DEQ_GAP);
  localparam logic          GAP_EN = (DEQ_GAP != 0);

  typedef enum logic {
    S_RUN = 1'b0,
    S_GAP = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_rr;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;

  logic w_fire;
  logic w_run;
  logic w_slot_free;
  logic w_deq_elig;
  logic w_enq_elig;
  logic w_bypass;
  logic w_contend;
  logic w_deq;
  logic w_enq;

  // Eligibility: queue operations only in RUN and never while reset is asserted.
  assign w_fire      = r_out_valid & ev_out_ready;
  assign w_run       = (r_state == S_RUN) & ~rst;
  assign w_slot_free = ~r_out_valid | w_fire;
  assign w_deq_elig  = w_run & (q_count != '0) & w_slot_free;
  assign w_enq_elig  = w_run & ev_in_valid & (q_count < CAP_C);

`ifdef PQ_BYPASS_EN
  assign w_bypass = w_run & (q_count == '0) & w_slot_free & ev_in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // Round-robin flag low favours dequeue when both operations compete.
  assign w_contend = w_deq_elig & w_enq_elig & ~w_bypass;
  assign w_deq     = w_deq_elig & ~(w_contend & r_rr);
  assign w_enq     = w_enq_elig & ~w_bypass & ~(w_contend & ~r_rr);

  assign q_deq        = w_deq;
  assign q_enq        = w_enq;
  assign ev_in_ready  = w_enq | w_bypass;
  assign q_inp_data   = ev_in_data;
  assign q_rst_n      = ~rst;
  assign ev_out_valid = r_out_valid;
  assign ev_out_data  = r_out_data;

  // Output buffer, arbitration flag and RUN/GAP sequencing.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_gap_cnt   <= '0;
      r_rr        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_contend) begin
        r_rr <= ~r_rr;
      end

      if (w_deq) begin
        r_out_valid <= 1'b1;
        r_out_data  <= q_out_data;
      end else if (w_bypass) begin
        r_out_valid <= 1'b1;
        r_out_data  <= ev_in_data;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_RUN: begin
          if (w_deq && GAP_EN) begin
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_C;
          end
        end
        S_GAP: begin
          if (r_gap_cnt <= GW'(1)) begin
            r_state   <= S_RUN;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_state   <= S_RUN;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule
